// File: rtl/meas_scan_ctrl_if.sv
// Handshake bundle between the measurement scan controller and its mux/consumer.
// The slave modport is the controller's view; master is the requester/consumer side.
interface meas_scan_ctrl_if #(
    parameter int C_IDWIDTH = 24,
    parameter int C_ISWIDTH = 6
);
    logic                 I_start;
    logic [C_ISWIDTH-1:0] I_first;
    logic [C_ISWIDTH-1:0] I_last;
    logic                 I_abort;
    logic [C_IDWIDTH-1:0] I_mux_data;
    logic                 I_ready;
    logic [C_ISWIDTH-1:0] O_sel;
    logic [C_IDWIDTH-1:0] O_data;
    logic [C_ISWIDTH-1:0] O_chan;
    logic                 O_valid;
    logic                 O_busy;
    logic                 O_done;
    logic                 O_err;

    modport slave (
        input  I_start, I_first, I_last, I_abort, I_mux_data, I_ready,
        output O_sel, O_data, O_chan, O_valid, O_busy, O_done, O_err
    );

    modport master (
        output I_start, I_first, I_last, I_abort, I_mux_data, I_ready,
        input  O_sel, O_data, O_chan, O_valid, O_busy, O_done, O_err
    );
endinterface

// File: rtl/meas_scan_ctrl.sv
// Scans a contiguous range of mux channels: select, wait a settle time, capture,
// and hand each sample to the consumer with a valid/ready handshake.
module meas_scan_ctrl #(
    parameter int C_INUM    = 48,
    parameter int C_IDWIDTH = 24,
    parameter int C_ISWIDTH = 6,
    parameter int C_SETTLE  = 4
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    meas_scan_ctrl_if.slave  i_bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [C_ISWIDTH:0] LP_INUM     = (C_ISWIDTH+1)'(C_INUM);
    localparam logic [7:0]         LP_CNT_INIT = 8'(C_SETTLE - 1);

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [C_ISWIDTH-1:0] r_last;
    logic [C_ISWIDTH-1:0] r_sel;
    logic [C_IDWIDTH-1:0] r_data;
    logic [C_ISWIDTH-1:0] r_chan;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_bad_range;
    logic                 w_accept;

    assign w_bad_range = (i_bus.I_first > i_bus.I_last) ||
                         ({1'b0, i_bus.I_last} >= LP_INUM);
    assign w_accept    = r_valid && i_bus.I_ready;

    // Scan FSM; every output is a register updated alongside the state.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_last  <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_bus.I_start) begin
                        if (w_bad_range) begin
                            r_err <= 1'b1;
                        end else begin
                            r_last  <= i_bus.I_last;
                            r_sel   <= i_bus.I_first;
                            r_cnt   <= LP_CNT_INIT;
                            r_busy  <= 1'b1;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (i_bus.I_abort) begin
                        r_cnt   <= 8'd0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        r_data  <= i_bus.I_mux_data;
                        r_chan  <= r_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    // Abort wins over a same-cycle acceptance, so no done pulse follows.
                    if (i_bus.I_abort) begin
                        r_cnt   <= 8'd0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                        if (r_sel != r_last) begin
                            r_sel   <= r_sel + C_ISWIDTH'(1);
                            r_cnt   <= LP_CNT_INIT;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_cnt   <= 8'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= 8'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_bus.O_sel   = r_sel;
    assign i_bus.O_data  = r_data;
    assign i_bus.O_chan  = r_chan;
    assign i_bus.O_valid = r_valid;
    assign i_bus.O_busy  = r_busy;
    assign i_bus.O_done  = r_done;
    assign i_bus.O_err   = r_err;

endmodule

// File: tb/tb_meas_scan_ctrl.sv
// Directed bench for meas_scan_ctrl: a cycle table for the basic scans and
// hand-written sequences for stalls, aborts and asynchronous reset.
module tb_meas_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    meas_scan_ctrl_if #(.C_IDWIDTH(24), .C_ISWIDTH(6)) vif ();

    meas_scan_ctrl #(
        .C_INUM(48), .C_IDWIDTH(24), .C_ISWIDTH(6), .C_SETTLE(4)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .i_bus   (vif)
    );

    // Mux model: each channel returns a distinct pattern.
    assign vif.I_mux_data = 24'hA50000 | {18'd0, vif.O_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [5:0] first;
        logic [5:0] last;
        logic       ready;
        logic       exp_valid;
        logic [5:0] exp_sel;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
        logic [5:0] exp_chan;
    } vec_t;

    vec_t tbl [28];

    function automatic logic [23:0] exp_data(input logic [5:0] c);
        return 24'hA50000 | {18'd0, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!vif.O_valid && n < budget) begin
            step();
            n++;
        end
        chk("wait_valid", 64'(vif.O_valid), 64'd1);
    endtask

    task automatic start_scan(input logic [5:0] f, input logic [5:0] l);
        vif.I_start = 1'b1;
        vif.I_first = f;
        vif.I_last  = l;
        step();
        vif.I_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        //          start first  last  rdy  v   sel  busy done err chan
        tbl[0]  = '{1'b1, 6'd2, 6'd4, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[3]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[4]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 6'd2};
        tbl[5]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[7]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[8]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[9]  = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 6'd3};
        tbl[10] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[11] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[12] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[13] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[14] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 6'd4};
        tbl[15] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b1, 1'b0, 6'd0};
        tbl[16] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[17] = '{1'b1, 6'd5, 6'd3, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, 6'd0};
        tbl[18] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[19] = '{1'b1, 6'd0, 6'd48, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1, 6'd0};
        tbl[20] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[21] = '{1'b1, 6'd7, 6'd7, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[22] = '{1'b1, 6'd0, 6'd1, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[23] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[24] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[25] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 6'd7};
        tbl[26] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 6'd0};
        tbl[27] = '{1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0, 6'd0};

        rst_n       = 1'b0;
        vif.I_start = 1'b0;
        vif.I_first = 6'd0;
        vif.I_last  = 6'd0;
        vif.I_abort = 1'b0;
        vif.I_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({vif.O_sel, vif.O_data, vif.O_chan, vif.O_valid,
                                  vif.O_busy, vif.O_done, vif.O_err}), 64'd0);
        rst_n = 1'b1;

        // Table: scan 2..4, bad ranges, single channel 7, start ignored while busy.
        for (int i = 0; i < 28; i++) begin
            vif.I_start = tbl[i].start;
            vif.I_first = tbl[i].first;
            vif.I_last  = tbl[i].last;
            vif.I_ready = tbl[i].ready;
            step();
            chk($sformatf("row%0d_ctrl", i),
                64'({vif.O_valid, vif.O_sel, vif.O_busy, vif.O_done, vif.O_err}),
                64'({tbl[i].exp_valid, tbl[i].exp_sel, tbl[i].exp_busy,
                     tbl[i].exp_done, tbl[i].exp_err}));
            if (tbl[i].exp_valid) begin
                chk($sformatf("row%0d_sample", i), 64'({vif.O_chan, vif.O_data}),
                    64'({tbl[i].exp_chan, exp_data(tbl[i].exp_chan)}));
            end
        end
        vif.I_start = 1'b0;

        // Consumer stalls for 10 cycles on channel 1.
        vif.I_ready = 1'b0;
        start_scan(6'd1, 6'd2);
        repeat (4) step();
        chk("stall_first_valid", 64'(vif.O_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stall_hold", 64'({vif.O_valid, vif.O_chan, vif.O_data, vif.O_sel}),
                64'({1'b1, 6'd1, exp_data(6'd1), 6'd1}));
        end
        vif.I_ready = 1'b1;
        step();
        chk("stall_advance", 64'({vif.O_valid, vif.O_sel}), 64'({1'b0, 6'd2}));
        wait_valid(10);
        chk("stall_chan2", 64'({vif.O_chan, vif.O_data}), 64'({6'd2, exp_data(6'd2)}));
        step();
        chk("stall_done", 64'({vif.O_done, vif.O_valid}), 64'({1'b1, 1'b0}));
        step();
        chk("stall_idle", 64'({vif.O_busy, vif.O_done}), 64'd0);

        // Abort coincident with acceptance of the last sample.
        vif.I_ready = 1'b0;
        start_scan(6'd3, 6'd3);
        repeat (4) step();
        chk("abort_hold_valid", 64'({vif.O_valid, vif.O_chan}), 64'({1'b1, 6'd3}));
        vif.I_ready = 1'b1;
        vif.I_abort = 1'b1;
        step();
        vif.I_abort = 1'b0;
        chk("abort_idle", 64'({vif.O_busy, vif.O_valid, vif.O_done}), 64'd0);
        step();
        chk("abort_no_done", 64'({vif.O_busy, vif.O_done}), 64'd0);
        start_scan(6'd0, 6'd1);
        chk("restart_busy", 64'(vif.O_busy), 64'd1);
        wait_valid(10);
        chk("restart_chan0", 64'(vif.O_chan), 64'd0);
        step();
        chk("restart_adv", 64'({vif.O_valid, vif.O_sel}), 64'({1'b0, 6'd1}));
        wait_valid(10);
        chk("restart_chan1", 64'({vif.O_chan, vif.O_data}), 64'({6'd1, exp_data(6'd1)}));
        step();
        chk("restart_done", 64'(vif.O_done), 64'd1);
        step();
        chk("restart_idle", 64'(vif.O_busy), 64'd0);

        // Abort during settle, before any capture.
        start_scan(6'd0, 6'd5);
        step();
        vif.I_abort = 1'b1;
        step();
        vif.I_abort = 1'b0;
        chk("abort_settle", 64'({vif.O_busy, vif.O_valid, vif.O_done}), 64'd0);
        repeat (5) step();
        chk("abort_settle_stays", 64'({vif.O_busy, vif.O_valid}), 64'd0);

        // Asynchronous reset in HOLD, between clock edges.
        vif.I_ready = 1'b0;
        start_scan(6'd1, 6'd1);
        repeat (4) step();
        chk("rst_pre_valid", 64'(vif.O_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 64'({vif.O_sel, vif.O_data, vif.O_chan, vif.O_valid,
                                    vif.O_busy, vif.O_done, vif.O_err}), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("rst_wait_idle", 64'({vif.O_busy, vif.O_valid}), 64'd0);
        vif.I_ready = 1'b1;
        start_scan(6'd2, 6'd2);
        wait_valid(10);
        chk("rst_new_scan", 64'({vif.O_chan, vif.O_data}), 64'({6'd2, exp_data(6'd2)}));
        step();
        chk("rst_new_done", 64'(vif.O_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/meas_scan_ctrl.md
MEAS_SCAN_CTRL -- requirements
Module: meas_scan_ctrl

Interface
REQ-001 Parameter C_INUM, default 48: number of measurement channels on the mux.
REQ-002 Parameter C_IDWIDTH, default 24: channel data width.
REQ-003 Parameter C_ISWIDTH, default 6: channel select width.
REQ-004 Parameter C_SETTLE, default 4: settle cycles after each select change; legal range 1..255.
REQ-005 I_clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 I_rst_n  input  1  asynchronous active-low reset.
REQ-007 I_start  input  1  scan request; sampled only in IDLE.
REQ-008 I_first  input  C_ISWIDTH  first channel of the scan; latched with I_start.
REQ-009 I_last  input  C_ISWIDTH  last channel of the scan; latched with I_start.
REQ-010 I_abort  input  1  terminate the scan in progress.
REQ-011 I_mux_data  input  C_IDWIDTH  muxed channel data returned for O_sel.
REQ-012 O_sel  output  C_ISWIDTH  channel select driven to the mux.
REQ-013 O_data  output  C_IDWIDTH  captured sample.
REQ-014 O_chan  output  C_ISWIDTH  channel index of O_data.
REQ-015 O_valid  output  1  O_data/O_chan valid.
REQ-016 I_ready  input  1  consumer accepts the sample when O_valid and I_ready are both high.
REQ-017 O_busy  output  1  high in every state except IDLE.
REQ-018 O_done  output  1  one-cycle pulse after the last sample is accepted.
REQ-019 O_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 FSM states shall be IDLE, SETTLE, HOLD and DONE; every output shall be registered.
REQ-021 In IDLE, with I_start=1 and (I_first>I_last or I_last>=C_INUM), the block shall pulse O_err for the following cycle and remain in IDLE.
REQ-022 In IDLE, with a valid I_start, the block shall latch I_last, load O_sel<=I_first, load the settle counter with C_SETTLE-1, and enter SETTLE.
REQ-023 In SETTLE, the counter shall decrement each cycle; in the cycle where it equals 0, the block shall capture O_data<=I_mux_data and O_chan<=O_sel, set O_valid=1, and enter HOLD.
REQ-024 The first O_valid shall therefore appear C_SETTLE+1 cycles after the I_start cycle; I_mux_data is guaranteed stable for C_SETTLE cycles before capture.
REQ-025 In HOLD, O_valid, O_data and O_chan shall be held unchanged until acceptance; O_sel shall not change while in HOLD.
REQ-026 On acceptance with O_sel!=last, the block shall clear O_valid, increment O_sel, reload the counter with C_SETTLE-1, and enter SETTLE.
REQ-027 On acceptance with O_sel==last, the block shall clear O_valid and enter DONE; DONE shall drive O_done=1 for exactly one cycle, then return to IDLE.
REQ-028 With I_first==I_last, the block shall produce exactly one sample followed by O_done.
REQ-029 I_abort=1 in SETTLE, HOLD or DONE shall force IDLE on the next edge with O_valid=0 and no O_done pulse; I_abort shall take priority over acceptance in the same cycle.
REQ-030 I_start outside IDLE shall be ignored; I_abort in IDLE shall have no effect.
REQ-031 O_sel shall never exceed the latched last value and shall never wrap around.

Reset
REQ-032 When I_rst_n=0, the block shall immediately force state IDLE, O_sel=0, O_data=0, O_chan=0, O_valid=0, O_busy=0, O_done=0, O_err=0, and counter=0, independent of I_clk.
REQ-033 A reset asserted mid-scan shall discard the scan; after release, the block shall wait in IDLE for a new I_start.

Verification
REQ-034 C_SETTLE=4, I_start with first=2 and last=4, I_ready=1 held -> samples on chan 2,3,4, each with O_valid one cycle, the first in cycle 5; O_done one cycle after chan 4 is accepted.
REQ-035 first=7, last=7 -> exactly one sample (chan 7), then an O_done pulse, then O_busy=0.
REQ-036 first=5, last=3, and separately last=48 -> O_err pulse, O_busy stays 0, no O_valid.
REQ-037 I_ready=0 for 10 cycles during HOLD on chan 1 -> O_valid, O_data and O_chan stable; O_sel=1 throughout; advance only after I_ready=1.
REQ-038 I_abort in the same cycle as acceptance of the last sample -> IDLE, no O_done; a subsequent I_start is accepted normally.
REQ-039 I_rst_n pulsed low asynchronously mid-HOLD -> all outputs 0 without a clock edge; a new scan works after release.
